// File: rtl/alarm_seq_ctrl_if.sv
// rtl/alarm_seq_ctrl_if.sv - keypad/sensor inputs and annunciator outputs of the alarm sequencer
interface alarm_seq_ctrl_if #(
  parameter int CNT_W = 6
);
  logic             arm;
  logic             disarm;
  logic             panic;
  logic             window;
  logic             door;
  logic             garage;
  logic             enable;
  logic             exiting;
  logic             siren;
  logic             alarm_mem;
  logic             arm_fault;
  logic [2:0]       state;
  logic [CNT_W-1:0] count;

  modport master (
    output arm, disarm, panic, window, door, garage,
    input  enable, exiting, siren, alarm_mem, arm_fault, state, count
  );

  modport slave (
    input  arm, disarm, panic, window, door, garage,
    output enable, exiting, siren, alarm_mem, arm_fault, state, count
  );
endinterface

// File: rtl/alarm_seq_ctrl.sv
// rtl/alarm_seq_ctrl.sv - timed arm/exit/entry/siren sequencer for the home-security alarm
module alarm_seq_ctrl #(
  parameter int EXIT_CYCLES  = 16,
  parameter int ENTRY_CYCLES = 8,
  parameter int SIREN_CYCLES = 32,
  parameter int CNT_W        = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  alarm_seq_ctrl_if.slave  bus
);
  typedef enum logic [2:0] {
    DISARMED    = 3'd0,
    EXIT_DELAY  = 3'd1,
    ARMED       = 3'd2,
    ENTRY_DELAY = 3'd3,
    ALARM       = 3'd4,
    SILENCED    = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_CYCLES - 1);
  localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             fault_q, fault_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DISARMED;
      count_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      fault_q <= fault_d;
    end
  end

  // Counter is loaded on state entry and only ever counts down to zero.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    fault_d = 1'b0;
    if (bus.panic) begin
      state_d = ALARM;
      count_d = SIREN_LOAD;
    end else if (bus.disarm) begin
      state_d = DISARMED;
      count_d = '0;
    end else begin
      case (state_q)
        DISARMED: begin
          if (bus.arm) begin
            if (bus.window || bus.door || bus.garage) begin
              fault_d = 1'b1;
            end else begin
              state_d = EXIT_DELAY;
              count_d = EXIT_LOAD;
            end
          end
        end
        EXIT_DELAY: begin
          if (count_q == '0) state_d = ARMED;
          else               count_d = count_q - 1'b1;
        end
        ARMED: begin
          if (bus.window || bus.garage) begin
            state_d = ALARM;
            count_d = SIREN_LOAD;
          end else if (bus.door) begin
            state_d = ENTRY_DELAY;
            count_d = ENTRY_LOAD;
          end
        end
        ENTRY_DELAY: begin
          if (bus.window || bus.garage || count_q == '0) begin
            state_d = ALARM;
            count_d = SIREN_LOAD;
          end else begin
            count_d = count_q - 1'b1;
          end
        end
        ALARM: begin
          if (count_q == '0) state_d = SILENCED;
          else               count_d = count_q - 1'b1;
        end
        SILENCED: begin
          state_d = SILENCED;
        end
        default: begin
          state_d = DISARMED;
          count_d = '0;
        end
      endcase
    end
  end

  assign bus.state     = state_q;
  assign bus.count     = count_q;
  assign bus.arm_fault = fault_q;
  assign bus.enable    = (state_q == EXIT_DELAY) || (state_q == ARMED) ||
                         (state_q == ENTRY_DELAY) || (state_q == ALARM) ||
                         (state_q == SILENCED);
  assign bus.exiting   = (state_q == EXIT_DELAY);
  assign bus.siren     = (state_q == ALARM);
  assign bus.alarm_mem = (state_q == ALARM) || (state_q == SILENCED);
endmodule

// File: tb/tb_alarm_seq_ctrl.sv
// tb/tb_alarm_seq_ctrl.sv - directed bench for alarm_seq_ctrl with EXIT=4, ENTRY=3, SIREN=5
module tb_alarm_seq_ctrl;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  alarm_seq_ctrl_if #(.CNT_W(6)) bus ();

  alarm_seq_ctrl #(
    .EXIT_CYCLES(4), .ENTRY_CYCLES(3), .SIREN_CYCLES(5), .CNT_W(6)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] st, input logic [5:0] cnt,
                         input logic en, input logic ex, input logic sr, input logic mem);
    chk({tag, ".state"},     32'(bus.state),     32'(st));
    chk({tag, ".count"},     32'(bus.count),     32'(cnt));
    chk({tag, ".enable"},    32'(bus.enable),    32'(en));
    chk({tag, ".exiting"},   32'(bus.exiting),   32'(ex));
    chk({tag, ".siren"},     32'(bus.siren),     32'(sr));
    chk({tag, ".alarm_mem"}, 32'(bus.alarm_mem), 32'(mem));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.arm = 0; bus.disarm = 0; bus.panic = 0;
    bus.window = 0; bus.door = 0; bus.garage = 0;
    #12;
    chk_all("reset", 3'd0, 6'd0, 0, 0, 0, 0);
    chk("reset.arm_fault", 32'(bus.arm_fault), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_reset.state", 32'(bus.state), 32'd0);

    // arm with sensors closed, exit delay lasts 4 cycles
    bus.arm = 1; tick(); bus.arm = 0;
    chk_all("arm", 3'd1, 6'd3, 1, 1, 0, 0);
    tick(3);
    chk_all("exit_last", 3'd1, 6'd0, 1, 1, 0, 0);
    tick();
    chk_all("armed", 3'd2, 6'd0, 1, 0, 0, 0);

    // door opens: entry delay of 3 cycles then siren of 5
    bus.door = 1; tick(); bus.door = 0;
    chk_all("entry", 3'd3, 6'd2, 1, 0, 0, 0);
    tick(2);
    chk_all("entry_last", 3'd3, 6'd0, 1, 0, 0, 0);
    tick();
    chk_all("alarm", 3'd4, 6'd4, 1, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("siren_on%0d", i), 32'(bus.siren), 32'd1);
      tick();
    end
    chk_all("silenced", 3'd5, 6'd0, 1, 0, 0, 1);
    bus.door = 1; bus.window = 1; bus.garage = 1; tick();
    bus.door = 0; bus.window = 0; bus.garage = 0;
    chk("silenced_sensors.state", 32'(bus.state), 32'd5);
    bus.disarm = 1; tick(); bus.disarm = 0;
    chk_all("disarm_silenced", 3'd0, 6'd0, 0, 0, 0, 0);

    // arm refused while door open, fault pulse is one cycle
    bus.door = 1; bus.arm = 1; tick(); bus.arm = 0;
    chk("fault.state", 32'(bus.state), 32'd0);
    chk("fault.arm_fault", 32'(bus.arm_fault), 32'd1);
    tick();
    chk("fault_clear.arm_fault", 32'(bus.arm_fault), 32'd0);
    bus.door = 0; bus.arm = 1; tick(); bus.arm = 0;
    chk("rearm.state", 32'(bus.state), 32'd1);
    chk("rearm.arm_fault", 32'(bus.arm_fault), 32'd0);
    tick(4);
    chk("rearm_armed.state", 32'(bus.state), 32'd2);

    // disarm on second entry-delay cycle
    bus.door = 1; tick(); bus.door = 0;
    chk("entry2.state", 32'(bus.state), 32'd3);
    tick();
    chk("entry2.count", 32'(bus.count), 32'd1);
    bus.disarm = 1; tick(); bus.disarm = 0;
    chk_all("entry_disarm", 3'd0, 6'd0, 0, 0, 0, 0);
    chk("entry_disarm.arm_fault", 32'(bus.arm_fault), 32'd0);

    // window during entry delay goes straight to alarm
    bus.arm = 1; tick(); bus.arm = 0;
    tick(4);
    chk("armed3.state", 32'(bus.state), 32'd2);
    bus.door = 1; tick(); bus.door = 0;
    chk("entry3.state", 32'(bus.state), 32'd3);
    bus.window = 1; tick(); bus.window = 0;
    chk_all("entry_window", 3'd4, 6'd4, 1, 0, 1, 1);
    bus.disarm = 1; tick(); bus.disarm = 0;
    chk("disarm3.state", 32'(bus.state), 32'd0);

    // panic from disarmed: 5-cycle siren
    bus.panic = 1; tick(); bus.panic = 0;
    chk_all("panic", 3'd4, 6'd4, 1, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("panic_siren%0d", i), 32'(bus.siren), 32'd1);
      tick();
    end
    chk_all("panic_silenced", 3'd5, 6'd0, 1, 0, 0, 1);

    // panic beats disarm and reloads the counter
    bus.panic = 1; tick(); bus.panic = 0;
    tick(2);
    chk("panic2.count", 32'(bus.count), 32'd2);
    bus.panic = 1; bus.disarm = 1; tick(); bus.panic = 0; bus.disarm = 0;
    chk_all("panic_disarm", 3'd4, 6'd4, 1, 0, 1, 1);
    bus.disarm = 1; tick(); bus.disarm = 0;
    chk("disarm4.state", 32'(bus.state), 32'd0);

    // asynchronous reset mid exit delay
    bus.arm = 1; tick(); bus.arm = 0;
    tick();
    chk_all("exit_mid", 3'd1, 6'd2, 1, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_reset", 3'd0, 6'd0, 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    tick();
    chk_all("after_release", 3'd0, 6'd0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alarm_seq_ctrl.md
Name: alarm_seq_ctrl

Overview:
Sequential controller for the home-security alarm logic. It turns the level inputs panic/window/door/garage and user arm/disarm pulses into a timed arming sequence: exit delay, armed, entry delay, siren, silenced. It generates the enable and exiting qualifiers for the combinational alarm block and drives the siren with a bounded on-time. It sits between the keypad/sensor inputs and the annunciator outputs.

Parameters:
EXIT_CYCLES, 16, clock cycles spent in EXIT_DELAY before ARMED (1..2^CNT_W)
ENTRY_CYCLES, 8, clock cycles allowed in ENTRY_DELAY before ALARM (1..2^CNT_W)
SIREN_CYCLES, 32, clock cycles the siren is driven in ALARM (1..2^CNT_W)
CNT_W, 6, width of the shared delay counter

Ports:
clk  in  1  system clock; all state changes on rising edge
rst_n  in  1  asynchronous active-low reset
arm  in  1  arm request, sampled each cycle, one-cycle pulse expected
disarm  in  1  disarm request, sampled each cycle
panic  in  1  panic button, level
window  in  1  window sensor, 1 = open
door  in  1  door sensor, 1 = open
garage  in  1  garage sensor, 1 = open
enable  out  1  system armed qualifier (1 in EXIT_DELAY, ARMED, ENTRY_DELAY, ALARM, SILENCED)
exiting  out  1  1 only in EXIT_DELAY
siren  out  1  1 only in ALARM
alarm_mem  out  1  1 in ALARM and SILENCED (alarm occurred, not yet cleared)
arm_fault  out  1  one-cycle pulse: arm refused because a sensor was open
state  out  3  current state code
count  out  CNT_W  remaining cycles of the active delay, 0 when no delay is running

Behaviour:
- Single clock domain. Interface as decided: one clock; reset is asynchronous and active-low.
- Reset is asynchronous on rst_n low. All outputs are 0 and state is DISARMED. Reset asserted mid-sequence aborts any delay or siren immediately. The first edge after release evaluates normally.
- State codes: DISARMED=0, EXIT_DELAY=1, ARMED=2, ENTRY_DELAY=3, ALARM=4, SILENCED=5. Codes 6 and 7 return to DISARMED on the next edge.
- All outputs are registered, or decoded from registered state and counter only. Every response appears on the edge after the sampled input, with no combinational input-to-output path.
- Per-cycle priority: panic > disarm > arm > sensors > counter expiry.
- panic=1 in any state, including DISARMED and SILENCED: next state ALARM and count=SIREN_CYCLES-1. panic held high keeps reloading the counter, so the siren stays on until panic drops plus SIREN_CYCLES.
- disarm=1 with panic=0 in any state: next state DISARMED and count=0.
- DISARMED:
  - arm=1 with window|door|garage=0: go to EXIT_DELAY with count=EXIT_CYCLES-1.
  - arm=1 with any sensor open: stay in DISARMED and pulse arm_fault for one cycle.
  - arm in any other state is ignored.
- EXIT_DELAY:
  - Sensors are ignored.
  - count decrements each cycle. The edge that sees count=0 moves to ARMED. Total dwell is exactly EXIT_CYCLES cycles.
- ARMED:
  - window|garage=1: go to ALARM with count=SIREN_CYCLES-1.
  - Otherwise door=1: go to ENTRY_DELAY with count=ENTRY_CYCLES-1.
  - window/garage take precedence over door when both are open.
- ENTRY_DELAY:
  - window|garage=1: go to ALARM immediately.
  - Otherwise decrement; count=0 moves to ALARM.
  - door returning to 0 does not cancel the delay; only disarm does.
- ALARM: siren=1. Decrement; count=0 moves to SILENCED. Dwell is exactly SIREN_CYCLES cycles.
- SILENCED: siren=0 and alarm_mem=1. It leaves only on disarm (to DISARMED) or panic (to ALARM). Sensor activity is ignored.
- count never wraps. It is loaded only on state entry and decremented only while non-zero.

Test Plan:
- Bench uses EXIT=4, ENTRY=3, SIREN=5. Reset, then arm pulse with all sensors 0 → state=1, exiting=1, count=3. After exactly 4 cycles state=2, enable=1, exiting=0.
- DISARMED, door=1, arm pulse → state stays 0 and arm_fault=1 for exactly one cycle. Repeat with door=0 → state=1, arm_fault=0.
- ARMED, door=1 → state=3. No disarm → state=4, siren=1 after 3 cycles. siren stays high 5 cycles, then state=5, siren=0, alarm_mem=1.
- ARMED→ENTRY_DELAY, disarm on the 2nd cycle → state=0 and all outputs 0. Separately, window=1 in ENTRY_DELAY → state=4 next edge.
- DISARMED, panic=1 for 1 cycle → state=4, enable=1, siren=1 for 5 cycles. Panic and disarm asserted together in ALARM → state remains 4 and count reloads to 4.
- Mid EXIT_DELAY (count=2), pulse rst_n low between clock edges → outputs 0 immediately without a clock edge. After release state=0.
